// File: rtl/rv32i_types.sv
// Shared RV32I MEM-stage types: load/store size codes, stage FSM states,
// and the misalignment predicate used by the optional trap path.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   f3_misaligned = off[0];
            2'b10:   f3_misaligned = (off != 2'b00);
            default: f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the MEM stage. Store side builds byte enables and
// lane-replicated write data; load side extracts and extends the addressed
// byte/half/word. Offset bits below the access size are ignored.
module mem_align
    import rv32i_types::*;
#(
    parameter  int XLEN   = 32,
    localparam int MASK_W = XLEN / 8,
    localparam int OFF_W  = $clog2(MASK_W)
) (
    input  logic [2:0]        st_funct3,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [XLEN-1:0]   st_rs2,
    output logic [MASK_W-1:0] st_wmask,
    output logic [XLEN-1:0]   st_wdata,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [OFF_W-1:0] ld_off_h, ld_off_w;
    logic [7:0]       lb;
    logic [15:0]      lh;
    logic [31:0]      lw;

    assign ld_off_h = ld_off & ~OFF_W'(1);
    assign ld_off_w = ld_off & ~OFF_W'(3);
    assign lb = 8'(ld_rdata >> {ld_off, 3'b000});
    assign lh = 16'(ld_rdata >> {ld_off_h, 3'b000});
    assign lw = 32'(ld_rdata >> {ld_off_w, 3'b000});

    // store mask and replicated data; unknown size codes write the full word
    always_comb begin
        st_wmask = '1;
        st_wdata = st_rs2;
        case (st_funct3)
            SB: begin
                st_wmask = MASK_W'(1) << st_off;
                st_wdata = {MASK_W{st_rs2[7:0]}};
            end
            SH: begin
                st_wmask = MASK_W'(3) << (st_off & ~OFF_W'(1));
                st_wdata = {(MASK_W/2){st_rs2[15:0]}};
            end
            SW: begin
                st_wmask = MASK_W'(15) << (st_off & ~OFF_W'(3));
                st_wdata = {(MASK_W/4){st_rs2[31:0]}};
            end
            default: ;
        endcase
    end

    // load extract and sign/zero extension; unknown codes pass the full word
    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            LB:      ld_data = XLEN'($signed(lb));
            LH:      ld_data = XLEN'($signed(lh));
            LW:      ld_data = XLEN'($signed(lw));
            LBU:     ld_data = XLEN'(lb);
            LHU:     ld_data = XLEN'(lh);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// RV32I MEM stage: registers the EX payload, runs a one-outstanding dcache
// req/resp handshake, and drives a valid/ready register into WB.
// Optional MEM_MISALIGN_TRAP_EN: adds out_trap; misaligned half/word accesses
// complete in one cycle with no dcache request instead of being truncated.
module mem_stage_dcache
    import rv32i_types::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_regwrite,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [MASK_W-1:0] dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_resp,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_rd,
    output logic              out_regwrite
`ifdef MEM_MISALIGN_TRAP_EN
   ,output logic              out_trap
`endif
);

    localparam int OFF_W = $clog2(MASK_W);

    // payload parked while the dcache request is in flight
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   alu;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              regwrite;
        logic              is_load;
    } pend_t;

    mem_state_t        state, state_nxt;
    pend_t             pend;
    logic              accept, is_mem, mis, issue, resp_done;
    logic [MASK_W-1:0] st_wmask;
    logic [XLEN-1:0]   st_wdata, ld_data;

    assign is_mem = in_mem_read | in_mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = is_mem && f3_misaligned(in_funct3, in_alu[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign issue     = accept && is_mem && !mis;
    assign resp_done = (state == WAIT) && dmem_resp;

    mem_align #(.XLEN(XLEN)) u_align (
        .st_funct3 (in_funct3),
        .st_off    (in_alu[OFF_W-1:0]),
        .st_rs2    (in_rs2),
        .st_wmask  (st_wmask),
        .st_wdata  (st_wdata),
        .ld_funct3 (pend.funct3),
        .ld_off    (pend.alu[OFF_W-1:0]),
        .ld_rdata  (dmem_rdata),
        .ld_data   (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: leave IDLE only when a request is issued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)     state_nxt = WAIT;
            WAIT:    if (dmem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the WB slot is free or draining
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    // dcache request register, held stable until the response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr  <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            pend       <= '0;
        end else if (issue) begin
            dmem_read  <= in_mem_read;
            dmem_write <= in_mem_write && !in_mem_read;
            dmem_addr  <= ADDR_W'(in_alu) & ~ADDR_W'(MASK_W-1);
            dmem_wmask <= st_wmask;
            dmem_wdata <= st_wdata;
            pend       <= '{pc: in_pc, alu: in_alu, rd: in_rd, funct3: in_funct3,
                            regwrite: in_regwrite, is_load: in_mem_read};
        end else if (resp_done) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
        end
    end

    // WB output register; resp and accept are exclusive since accept needs IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_result   <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
        end else if (resp_done) begin
            out_valid    <= 1'b1;
            out_pc       <= pend.pc;
            out_rd       <= pend.rd;
            out_result   <= pend.is_load ? ld_data : pend.alu;
            out_regwrite <= pend.is_load && pend.regwrite;
        end else if (accept) begin
            if (issue) begin
                out_valid <= 1'b0;
            end else begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_result   <= in_alu;
                out_rd       <= in_rd;
                out_regwrite <= in_regwrite && !mis;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // trap flag follows the most recently accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_trap <= 1'b0;
        else if (accept) out_trap <= mis;
    end
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Scoreboard bench for mem_stage_dcache: directed stimulus pushes expected
// WB results; a negedge monitor pops on each out_valid/out_ready handshake.
module tb_mem_stage_dcache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_alu, in_rs2;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic        in_mem_read, in_mem_write, in_regwrite;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_result;
    logic [4:0]  out_rd;
    logic        out_regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        out_trap;
`endif

    always #5 clk = ~clk;

    mem_stage_dcache #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_regwrite(in_regwrite),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_result(out_result), .out_rd(out_rd), .out_regwrite(out_regwrite)
`ifdef MEM_MISALIGN_TRAP_EN
       ,.out_trap(out_trap)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // monitor: compare every WB handshake against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wb: pc 0x%08h result 0x%08h with empty scoreboard", out_pc, out_result);
            end else begin
                mon_e = q.pop_front();
                chk("wb_pc", out_pc, mon_e.pc);
                chk("wb_result", out_result, mon_e.res);
                chk("wb_rd", 32'(out_rd), 32'(mon_e.rd));
                chk("wb_regwrite", 32'(out_regwrite), 32'(mon_e.rw));
            end
        end
    end

    task automatic push(input logic [31:0] pc, res, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.pc = pc; e.res = res; e.rd = rd; e.rw = rw;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [31:0] pc, alu, rs2, input logic [4:0] rd,
                          input logic [2:0] f3, input logic mr, mw, rw);
        in_valid = 1'b1; in_pc = pc; in_alu = alu; in_rs2 = rs2; in_rd = rd;
        in_funct3 = f3; in_mem_read = mr; in_mem_write = mw; in_regwrite = rw;
    endtask

    // hold the payload until it is accepted at a posedge (bounded)
    task automatic wait_accept();
        bit acc = 1'b0;
        int n = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (!acc && ++n > 50) begin
                n_chk++; n_fail++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // drive the dcache side for an issued request and check it each WAIT cycle
    task automatic mem_op(input string tag, input logic [31:0] pc, alu, rs2, input logic [4:0] rd,
                          input logic [2:0] f3, input logic mr, mw, rw, input int waits,
                          input logic [31:0] rdata, exp_addr, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata, exp_res, input logic exp_rw,
                          input logic exp_rd_req, exp_wr_req);
        set_in(pc, alu, rs2, rd, f3, mr, mw, rw);
        wait_accept();
        push(pc, exp_res, rd, exp_rw);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin dmem_resp = 1'b1; dmem_rdata = rdata; end
            @(negedge clk);
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_dmem_read"}, 32'(dmem_read), 32'(exp_rd_req));
            chk({tag, "_dmem_write"}, 32'(dmem_write), 32'(exp_wr_req));
            chk({tag, "_dmem_addr"}, dmem_addr, exp_addr);
            if (exp_wr_req) begin
                chk({tag, "_wmask"}, 32'(dmem_wmask), 32'(exp_mask));
                chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
            end
            @(posedge clk); #1;
        end
        dmem_resp = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_req_drop"}, 32'(dmem_read | dmem_write), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; dmem_resp = 1'b0; dmem_rdata = '0;
        in_valid = 1'b0; in_pc = '0; in_alu = '0; in_rs2 = '0; in_rd = '0;
        in_funct3 = '0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_regwrite = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dmem_req", 32'({dmem_read, dmem_write}), 0);
        chk("rst_out_regwrite", 32'(out_regwrite), 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wmask", 32'(dmem_wmask), 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of WAIT kills the request; a stray resp is ignored
        set_in(32'h40, 32'h40, 0, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1);
        wait_accept();
        @(negedge clk);
        chk("midwait_dmem_read", 32'(dmem_read), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midwait_rst_read", 32'(dmem_read), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midwait_in_ready", 32'(in_ready), 1);
        chk("midwait_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1 dmem_resp = 1'b1; dmem_rdata = 32'hFFFF;
        @(posedge clk); #1 dmem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_out_valid", 32'(out_valid), 0);
        chk("late_resp_dmem_read", 32'(dmem_read), 0);
        @(posedge clk); #1;

        // back-to-back ALU ops: full throughput, no stall
        for (int i = 0; i < 4; i++) begin
            set_in(32'h10 + 32'(4*i), 32'h1234 + 32'(i), 0, 5'(3+i), 3'b000, 1'b0, 1'b0, 1'b1);
            push(32'h10 + 32'(4*i), 32'h1234 + 32'(i), 5'(3+i), 1'b1);
            @(negedge clk);
            chk("b2b_in_ready", 32'(in_ready), 1);
            if (i > 0) chk("b2b_out_valid", 32'(out_valid), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        //      tag    pc        alu       rs2          rd  f3      mr mw rw wt rdata         addr      mask     wdata         result        rw rd wr
        mem_op("lb",   32'h200, 32'h103, 0,            5,  3'b000, 1, 0, 1, 3, 32'h80FF_0000, 32'h100, 4'b0000, 0,            32'hFFFF_FF80, 1, 1, 0);
        mem_op("lbu",  32'h204, 32'h103, 0,            6,  3'b100, 1, 0, 1, 1, 32'h80FF_0000, 32'h100, 4'b0000, 0,            32'h0000_0080, 1, 1, 0);
        mem_op("sh",   32'h208, 32'h202, 32'hDEAD_BEEF, 7, 3'b001, 0, 1, 1, 0, 0,             32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h202,      0, 0, 1);
        mem_op("sb",   32'h20C, 32'h101, 32'h1234_56AB, 0, 3'b000, 0, 1, 0, 1, 0,             32'h100, 4'b0010, 32'hABAB_ABAB, 32'h101,      0, 0, 1);
        mem_op("sw",   32'h210, 32'h300, 32'hCAFE_F00D, 0, 3'b010, 0, 1, 0, 0, 0,             32'h300, 4'b1111, 32'hCAFE_F00D, 32'h300,      0, 0, 1);
        mem_op("lh",   32'h214, 32'h102, 0,            8,  3'b001, 1, 0, 1, 0, 32'h8001_1234, 32'h100, 4'b0000, 0,            32'hFFFF_8001, 1, 1, 0);
        mem_op("lhu",  32'h218, 32'h102, 0,            9,  3'b101, 1, 0, 1, 2, 32'h8001_1234, 32'h100, 4'b0000, 0,            32'h0000_8001, 1, 1, 0);
        mem_op("lh0",  32'h21C, 32'h100, 0,            10, 3'b001, 1, 0, 1, 0, 32'h8001_9234, 32'h100, 4'b0000, 0,            32'hFFFF_9234, 1, 1, 0);
        mem_op("lw",   32'h220, 32'h104, 0,            11, 3'b010, 1, 0, 1, 0, 32'h89AB_CDEF, 32'h104, 4'b0000, 0,            32'h89AB_CDEF, 1, 1, 0);
        mem_op("f3_011", 32'h224, 32'h108, 0,          12, 3'b011, 1, 0, 1, 0, 32'h0102_0304, 32'h108, 4'b0000, 0,            32'h0102_0304, 1, 1, 0);
        mem_op("rdwr", 32'h228, 32'h10C, 32'h1111,     13, 3'b010, 1, 1, 1, 1, 32'h55AA_55AA, 32'h10C, 4'b0000, 0,            32'h55AA_55AA, 1, 1, 0);
`ifndef MEM_MISALIGN_TRAP_EN
        mem_op("lh_off3", 32'h22C, 32'h103, 0,         14, 3'b001, 1, 0, 1, 0, 32'h8001_1234, 32'h100, 4'b0000, 0,            32'hFFFF_8001, 1, 1, 0);
        mem_op("lw_off1", 32'h230, 32'h101, 0,         15, 3'b010, 1, 0, 1, 0, 32'hA5A5_0F0F, 32'h100, 4'b0000, 0,            32'hA5A5_0F0F, 1, 1, 0);
`endif

        // WB backpressure: held output blocks a pending load until drained
        out_ready = 1'b0;
        set_in(32'h500, 32'h77, 0, 5'd7, 3'b000, 1'b0, 1'b0, 1'b1);
        wait_accept();
        push(32'h500, 32'h77, 5'd7, 1'b1);
        set_in(32'h504, 32'h108, 0, 5'd8, 3'b010, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_result", out_result, 32'h77);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_no_req", 32'(dmem_read), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push(32'h504, 32'h1122_3344, 5'd8, 1'b1);
        dmem_resp = 1'b1; dmem_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("bp_lw_read", 32'(dmem_read), 1);
        chk("bp_lw_addr", dmem_addr, 32'h108);
        @(posedge clk); #1 dmem_resp = 1'b0;
        @(negedge clk);
        chk("bp_lw_done", 32'(out_valid), 1);
        @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
        // misaligned word traps without touching the dcache; next op clears it
        set_in(32'h600, 32'h101, 0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1);
        wait_accept();
        push(32'h600, 32'h101, 5'd9, 1'b0);
        @(negedge clk);
        chk("trap_set", 32'(out_trap), 1);
        chk("trap_no_read", 32'(dmem_read), 0);
        chk("trap_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        set_in(32'h604, 32'h42, 0, 5'd10, 3'b000, 1'b0, 1'b0, 1'b1);
        wait_accept();
        push(32'h604, 32'h42, 5'd10, 1'b1);
        @(negedge clk);
        chk("trap_clear", 32'(out_trap), 0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
